// File: rtl/p2s_mux_tx.sv
// Multi-channel parallel-to-serial transmitter: loaded channel words are sent back-to-back in index order.
// Define P2S_PARITY_EN to append an even-parity bit after each word.
module p2s_mux_tx #(
  parameter int DATA_W    = 4,
  parameter int NUM_CH    = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              ck,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic [NUM_CH-1:0] ld,
  input  logic              start,
  output logic              out,
  output logic              vo,
  output logic              ok,
  output logic              busy,
  output logic [NUM_CH-1:0] loaded
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(DATA_W + 1);
`ifdef P2S_PARITY_EN
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);
`else
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  // Bit index DATA_W is the parity slot; below it the word bit in transmit order.
  function automatic logic pick_bit(input logic [DATA_W-1:0] word, input logic [BW-1:0] idx);
    logic [DATA_W-1:0] sh;
    logic              b;
    sh = '0;
    if (idx >= BW'(DATA_W)) begin
      b = even_parity(word);
    end else if (MSB_FIRST != 0) begin
      sh = word << idx;
      b  = sh[DATA_W-1];
    end else begin
      sh = word >> idx;
      b  = sh[0];
    end
    return b;
  endfunction

  logic [1:0]        r_state;
  logic [CW-1:0]     r_ch;
  logic [BW-1:0]     r_bit;
  logic [NUM_CH-1:0] r_set;
  logic [NUM_CH-1:0] r_loaded;
  logic [DATA_W-1:0] r_data [NUM_CH];
  logic              r_out;
  logic              r_vo;
  logic              r_ok;
  logic              r_busy;

  logic [1:0]        w_nxt_state;
  logic [CW-1:0]     w_nxt_ch;
  logic [BW-1:0]     w_nxt_bit;
  logic [NUM_CH-1:0] w_nxt_set;
  logic [NUM_CH-1:0] w_frame;
  logic [NUM_CH-1:0] w_scan_set;
  logic [CW-1:0]     w_scan_ch;
  logic              w_found;
  logic [DATA_W-1:0] w_word;

  // Lowest candidate channel: any frame member from IDLE, or the next one above r_ch while shifting.
  always_comb begin
    w_frame    = r_loaded | ld;
    w_scan_set = (r_state == IDLE) ? w_frame : r_set;
    w_scan_ch  = '0;
    w_found    = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_scan_set[i] && ((r_state == IDLE) || (CW'(i) > r_ch))) begin
        w_found   = 1'b1;
        w_scan_ch = CW'(i);
      end else begin
        w_found   = w_found;
      end
    end
  end

  // Frame sequencing.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ch    = r_ch;
    w_nxt_bit   = r_bit;
    w_nxt_set   = r_set;
    case (r_state)
      IDLE: begin
        if (start && (w_frame != '0)) begin
          w_nxt_state = SHIFT;
          w_nxt_set   = w_frame;
          w_nxt_ch    = w_scan_ch;
          w_nxt_bit   = '0;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      SHIFT: begin
        if (r_bit == LAST_BIT) begin
          if (w_found) begin
            w_nxt_ch  = w_scan_ch;
            w_nxt_bit = '0;
          end else begin
            w_nxt_state = DONE;
          end
        end else begin
          w_nxt_bit = r_bit + BW'(1);
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // A word loaded in the same cycle as start is not yet in r_data, so take it from din.
  always_comb begin
    if ((r_state == IDLE) && ld[w_nxt_ch]) begin
      w_word = din;
    end else begin
      w_word = r_data[w_nxt_ch];
    end
  end

  // Channel holding registers; writes only while idle.
  always_ff @(posedge ck) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_data[i] <= '0;
    end else if (r_state == IDLE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ld[i]) r_data[i] <= din;
      end
    end
  end

  // Sequencer state, loaded flags and registered outputs.
  always_ff @(posedge ck) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_bit    <= '0;
      r_set    <= '0;
      r_loaded <= '0;
      r_out    <= 1'b0;
      r_vo     <= 1'b0;
      r_ok     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ch    <= w_nxt_ch;
      r_bit   <= w_nxt_bit;
      r_set   <= w_nxt_set;
      if (r_state == IDLE) begin
        r_loaded <= w_frame;
      end else if (w_nxt_state == DONE) begin
        r_loaded <= r_loaded & ~r_set;
      end else begin
        r_loaded <= r_loaded;
      end
      r_out  <= (w_nxt_state == SHIFT) ? pick_bit(w_word, w_nxt_bit) : 1'b0;
      r_vo   <= (w_nxt_state == SHIFT);
      r_busy <= (w_nxt_state == SHIFT);
      r_ok   <= (w_nxt_state == DONE);
    end
  end

  assign out    = r_out;
  assign vo     = r_vo;
  assign ok     = r_ok;
  assign busy   = r_busy;
  assign loaded = r_loaded;

endmodule

// File: tb/tb_p2s_mux_tx.sv
// Randomized and directed bench for p2s_mux_tx against a queue-based frame model.
// Honours P2S_PARITY_EN the same way as the design.
module tb_p2s_mux_tx;

  localparam int DATA_W    = 4;
  localparam int NUM_CH    = 2;
  localparam int MSB_FIRST = 1;
`ifdef P2S_PARITY_EN
  localparam int WL = DATA_W + 1;
  localparam logic [31:0] EXP_BASIC = 32'b1100010100;
  localparam logic [31:0] EXP_SKIP  = 32'b01100;
  localparam logic [31:0] EXP_SIM   = 32'b10010;
`else
  localparam int WL = DATA_W;
  localparam logic [31:0] EXP_BASIC = 32'b11001010;
  localparam logic [31:0] EXP_SKIP  = 32'b0110;
  localparam logic [31:0] EXP_SIM   = 32'b1001;
`endif

  logic              ck = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] din;
  logic [NUM_CH-1:0] ld;
  logic              start;
  logic              out, vo, ok, busy;
  logic [NUM_CH-1:0] loaded;

  p2s_mux_tx #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .MSB_FIRST(MSB_FIRST)) dut (
    .ck(ck), .reset(reset), .din(din), .ld(ld), .start(start),
    .out(out), .vo(vo), .ok(ok), .busy(busy), .loaded(loaded)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: idle / transmitting / frame-complete, with the remaining bits of the frame in a queue.
  localparam int M_IDLE = 0;
  localparam int M_TX   = 1;
  localparam int M_DONE = 2;
  int                m_mode = M_IDLE;
  logic [DATA_W-1:0] m_data [NUM_CH];
  logic [NUM_CH-1:0] m_loaded = '0;
  logic [NUM_CH-1:0] m_set = '0;
  bit                m_q[$];

  logic [31:0] cap;
  int          vo_n, ok_n, busy_n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst_v, input logic [DATA_W-1:0] din_v,
                              input logic [NUM_CH-1:0] ld_v, input logic start_v);
    logic [NUM_CH-1:0] snap;
    logic [DATA_W-1:0] w;
    if (rst_v) begin
      for (int c = 0; c < NUM_CH; c++) m_data[c] = '0;
      m_loaded = '0;
      m_q.delete();
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      snap = m_loaded | ld_v;
      for (int c = 0; c < NUM_CH; c++) if (ld_v[c]) m_data[c] = din_v;
      m_loaded = snap;
      if (start_v && (snap != '0)) begin
        m_set = snap;
        for (int c = 0; c < NUM_CH; c++) begin
          if (snap[c]) begin
            w = m_data[c];
            for (int k = 0; k < DATA_W; k++)
              m_q.push_back((MSB_FIRST != 0) ? w[DATA_W-1-k] : w[k]);
`ifdef P2S_PARITY_EN
            m_q.push_back(^w);
`endif
          end
        end
        m_mode = M_TX;
      end
    end else if (m_mode == M_TX) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_mode   = M_DONE;
        m_loaded = m_loaded & ~m_set;
      end
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  task automatic step(input logic rst_v, input logic [DATA_W-1:0] din_v,
                      input logic [NUM_CH-1:0] ld_v, input logic start_v);
    @(negedge ck);
    reset = rst_v; din = din_v; ld = ld_v; start = start_v;
    @(posedge ck);
    model_update(rst_v, din_v, ld_v, start_v);
    #1;
    check_eq("out",    32'(out),    (m_mode == M_TX) ? 32'(m_q[0]) : 32'd0);
    check_eq("vo",     32'(vo),     32'(m_mode == M_TX));
    check_eq("busy",   32'(busy),   32'(m_mode == M_TX));
    check_eq("ok",     32'(ok),     32'(m_mode == M_DONE));
    check_eq("loaded", 32'(loaded), 32'(m_loaded));
    if (vo) cap = {cap[30:0], out};
    if (vo) vo_n++;
    if (ok) ok_n++;
    if (busy) busy_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic clear_counts();
    cap = '0; vo_n = 0; ok_n = 0; busy_n = 0;
  endtask

  initial begin
    reset = 1'b1; din = '0; ld = '0; start = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_data[c] = '0;
    clear_counts();
    step(1'b1, '0, '0, 1'b0);
    check_eq("rst_state", {29'd0, out, vo, ok}, 32'd0);

    // basic two-channel frame
    step(1'b0, 4'b1100, 2'b01, 1'b0);
    step(1'b0, 4'b1010, 2'b10, 1'b0);
    clear_counts();
    step(1'b0, '0, '0, 1'b1);
    idle(2 * WL + 2);
    check_eq("basic_bits", cap, EXP_BASIC);
    check_eq("basic_len",  32'(vo_n), 32'(2 * WL));
    check_eq("basic_ok",   32'(ok_n), 32'd1);
    check_eq("basic_ld",   32'(loaded), 32'd0);

    // only channel 1 loaded
    step(1'b0, 4'b0110, 2'b10, 1'b0);
    clear_counts();
    step(1'b0, '0, '0, 1'b1);
    idle(WL + 2);
    check_eq("skip_bits", cap, EXP_SKIP);
    check_eq("skip_busy", 32'(busy_n), 32'(WL));
    check_eq("skip_ok",   32'(ok_n), 32'd1);

    // start with nothing loaded
    clear_counts();
    step(1'b0, '0, '0, 1'b1);
    idle(3);
    check_eq("empty_vo", 32'(vo_n), 32'd0);
    check_eq("empty_ok", 32'(ok_n), 32'd0);

    // load attempt while busy
    step(1'b0, 4'b0011, 2'b10, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, 4'b1111, 2'b01, 1'b0);
    idle(WL + 2);
    check_eq("busy_ld", 32'(loaded), 32'd0);

    // load in the same cycle as start
    clear_counts();
    step(1'b0, 4'b1001, 2'b01, 1'b1);
    idle(WL + 2);
    check_eq("sim_bits", cap, EXP_SIM);
    check_eq("sim_ok",   32'(ok_n), 32'd1);

    // reset in the middle of a frame
    step(1'b0, 4'b1010, 2'b11, 1'b0);
    clear_counts();
    step(1'b0, '0, '0, 1'b1);
    idle(2);
    step(1'b1, '0, '0, 1'b0);
    check_eq("abort_out", {29'd0, out, vo, busy}, 32'd0);
    check_eq("abort_ld",  32'(loaded), 32'd0);
    idle(2 * WL + 2);
    check_eq("abort_ok",  32'(ok_n), 32'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0),
           DATA_W'($urandom),
           ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0,
           ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/p2s_mux_tx.md
Name: p2s_mux_tx

Overview:
- Parametrised multi-channel parallel-to-serial transmitter. Successor to the two-register, 4-bit load/start serialiser.
- Holds NUM_CH parallel words of DATA_W bits, each loaded by its own strobe.
- On start, shifts every loaded word out on one serial line, back-to-back in channel-index order.
- Flags serial-data validity (vo) and frame completion (ok). Sits between parallel data producers and the serial transmission link.

Parameters:
- DATA_W, 4, bits per channel word (>=2)
- NUM_CH, 2, number of channel holding registers (>=1)
- MSB_FIRST, 1, 1 = word shifted MSB first; 0 = LSB first

Ports:
- ck  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- din  input  DATA_W  parallel data shared by all channel loads
- ld  input  NUM_CH  per-channel load strobe; bit i captures din into channel i
- start  input  1  begin transmission of all loaded channels
- out  output  1  serial data
- vo  output  1  high while out carries a valid data (or parity) bit
- ok  output  1  one-cycle pulse after the last bit of a frame
- busy  output  1  high from the cycle after an accepted start until ok
- loaded  output  NUM_CH  per-channel "word held, not yet sent" flags

Behaviour:
- Reset (sync, active-high; wins over all other inputs):
  - out=0, vo=0, ok=0, busy=0, loaded=0.
  - Holding registers cleared, FSM to IDLE.
  - Reset mid-frame aborts the frame immediately; no ok pulse.
- Load:
  - Accepted only in IDLE. ld[i]=1 captures din into channel i and sets loaded[i].
  - Several ld bits may be set together; all get the same din.
  - Reloading a loaded channel overwrites it.
  - ld while busy is ignored (no data, no flag change).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - out=0, vo=0.
  - start=1 with (loaded | ld) != 0 goes to SHIFT. The frame set is snapshotted as loaded | ld, so a same-cycle load is included.
  - start with no channel loaded is ignored and produces no ok.
- SHIFT:
  - First bit appears on out, vo=1, busy=1 in the cycle after start is sampled (latency 1).
  - Each word takes DATA_W consecutive cycles, bit order per MSB_FIRST.
  - Unloaded channels are skipped with zero gap cycles; vo stays high continuously across the frame.
  - start during SHIFT is ignored.
  - Channel index counter is max(1,$clog2(NUM_CH)) bits wide. Bit counter is $clog2(DATA_W+1) bits wide and wraps to 0 at each word boundary.
  - After the last bit of the highest-index snapshotted channel, go to DONE.
- DONE (exactly one cycle):
  - vo=0, out=0, ok=1, busy=0.
  - loaded bits of transmitted channels cleared.
  - Returns to IDLE. A new start is accepted from the following cycle.
- Frame length = DATA_W x (number of snapshotted channels) cycles, plus parity bits if enabled.

Optional Feature:
- Macro: P2S_PARITY_EN.
- Defined:
  - After each word's DATA_W bits, one extra cycle carries the even parity bit (XOR of the word), with vo=1.
  - Per-word length becomes DATA_W+1 and frame length grows accordingly.
- Undefined: no parity cycles; frame is data bits only. Ports are identical in both builds.

Test Plan (DATA_W=4, NUM_CH=2, MSB_FIRST=1, parity off unless noted):
- Basic frame: reset; ld[0] with din=1100; ld[1] with din=1010; start -> cycles 1..8 out=1,1,0,0,1,0,1,0, vo=1; cycle 9 ok=1, vo=0; loaded=00 afterwards.
- Skip: load only ch1=0110, start -> out=0,1,1,0 over 4 cycles, ok at cycle 5, busy high for cycles 1..4.
- Empty start and busy loads: start with loaded=00 -> no vo, no ok. Mid-frame ld[0] din=1111 -> ignored, loaded[0] stays 0.
- Simultaneous: ld[0] din=1001 in the same cycle as start -> frame 1,0,0,1, ok at cycle 5. Reset asserted at frame cycle 3 -> next cycle out=0, vo=0, loaded=00, no ok.
- LSB order: MSB_FIRST=0, ch0=1100 -> out=0,0,1,1.
- P2S_PARITY_EN: ch0=1100, ch1=1011 -> out=1,1,0,0,0,1,0,1,1,1; vo high 10 cycles; ok at cycle 11.
